// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes and sequencer state encoding for the ALU issue controller.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [2:0] OP_XOR   = 3'b011;
    localparam logic [2:0] OP_SPLIT = 3'b100;
    localparam logic [2:0] OP_MOD2  = 3'b101;
    localparam logic [2:0] OP_PASS  = 3'b110;
    localparam logic [2:0] OP_NOP   = 3'b111;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StZcap,
        StResp
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: round-robin on ties, or fixed priority to req[0] when FIXED_PRIO != 0.
module rr_arb2 #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // High when req[1] should win the next tie.
    logic ptr_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (FIXED_PRIO != 0 || !ptr_q) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= 1'b0;
        end else if (advance && gnt != 2'b00) begin
            ptr_q <= gnt[0];
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Arbitrates two requesters onto the registered ALU and returns LO/HI with ZERO realigned
// to the same result, hiding the one-cycle ZERO skew inside the ALU.
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned OP_W       = 3,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic [OP_W-1:0]   REQ0_OP,
    input  logic [DATA_W-1:0] REQ0_A,
    input  logic [DATA_W-1:0] REQ0_B,
    input  logic              REQ0_INCR,

    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic [OP_W-1:0]   REQ1_OP,
    input  logic [DATA_W-1:0] REQ1_A,
    input  logic [DATA_W-1:0] REQ1_B,
    input  logic              REQ1_INCR,

    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic              RSP_ID,
    output logic [DATA_W-1:0] RSP_LO,
    output logic [DATA_W-1:0] RSP_HI,
    output logic              RSP_ZERO,

    output logic              BUSY,

    output logic [OP_W-1:0]   ALU_OP,
    output logic [DATA_W-1:0] ALU_INPUTA,
    output logic [DATA_W-1:0] ALU_INPUTB,
    output logic              ALU_INCR_OP,
    input  logic [DATA_W-1:0] ALU_OUT_LO,
    input  logic [DATA_W-1:0] ALU_OUT_HI,
    input  logic              ALU_ZERO
);

    state_e              state_q;
    logic [OP_W-1:0]     alu_op_q;
    logic [DATA_W-1:0]   alu_a_q;
    logic [DATA_W-1:0]   alu_b_q;
    logic                alu_incr_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [DATA_W-1:0]   rsp_lo_q;
    logic [DATA_W-1:0]   rsp_hi_q;
    logic                rsp_zero_q;

    logic                grant_en;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic                take;
    logic [OP_W-1:0]     sel_op;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic                sel_incr;

    // Grants only from IDLE or on the response handshake; held off while RST is asserted.
    assign grant_en = !RST && (state_q == StIdle || (state_q == StResp && RSP_READY));
    assign req      = {REQ1_VALID, REQ0_VALID} & {2{grant_en}};

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .req     (req),
        .advance (grant_en),
        .gnt     (gnt)
    );

    assign REQ0_READY = gnt[0];
    assign REQ1_READY = gnt[1];
    assign take       = |gnt;

    assign sel_op   = gnt[1] ? REQ1_OP   : REQ0_OP;
    assign sel_a    = gnt[1] ? REQ1_A    : REQ0_A;
    assign sel_b    = gnt[1] ? REQ1_B    : REQ0_B;
    assign sel_incr = gnt[1] ? REQ1_INCR : REQ0_INCR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            alu_op_q    <= OP_W'(OP_NOP);
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_incr_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_lo_q    <= '0;
            rsp_hi_q    <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (take) begin
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    state_q <= StWait;
                end
                StWait: begin
                    rsp_lo_q <= ALU_OUT_LO;
                    rsp_hi_q <= ALU_OUT_HI;
                    state_q  <= StZcap;
                end
                StZcap: begin
                    // ZERO now reflects the OUT_LO captured one edge earlier.
                    rsp_zero_q  <= ALU_ZERO;
                    alu_op_q    <= OP_W'(OP_NOP);
                    alu_incr_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= take ? StIssue : StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (take) begin
                alu_op_q   <= sel_op;
                alu_a_q    <= sel_a;
                alu_b_q    <= sel_b;
                alu_incr_q <= sel_incr;
                rsp_id_q   <= gnt[1];
            end
        end
    end

    assign BUSY        = (state_q != StIdle);
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_ID      = rsp_id_q;
    assign RSP_LO      = rsp_lo_q;
    assign RSP_HI      = rsp_hi_q;
    assign RSP_ZERO    = rsp_zero_q;
    assign ALU_OP      = alu_op_q;
    assign ALU_INPUTA  = alu_a_q;
    assign ALU_INPUTB  = alu_b_q;
    assign ALU_INCR_OP = alu_incr_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Two-requester arbiter and sequencer for the registered 10-bit ALU.
- Accepts operation requests from two masters (req0 = execute stage, req1 = address/PC-increment path) over valid/ready handshakes.
- Grants one request at a time, drives the ALU operand/opcode lines, and returns the result with the correctly aligned ZERO flag.
- ZERO lags OUT_LO by one cycle inside the ALU; this block hides that skew.

Parameters:
- DATA_W, 10, operand/result width; must match the ALU.
- OP_W, 3, opcode width.
- FIXED_PRIO, 0, 0 = round-robin between req0/req1; 1 = req0 always wins.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- REQ0_VALID  in  1  requester 0 has an operation
- REQ0_READY  out  1  request 0 accepted this cycle
- REQ0_OP  in  OP_W  ALU opcode (000 ADD, 001 SUB, 010 MUL, 011 XOR, 100 SPLIT, 101 MOD2, 110 PASS)
- REQ0_A, REQ0_B  in  DATA_W  operands
- REQ0_INCR  in  1  increment request (A+1), overrides OP
- REQ1_VALID, REQ1_READY, REQ1_OP, REQ1_A, REQ1_B, REQ1_INCR: same as req0
- RSP_VALID  out  1  result available
- RSP_READY  in  1  consumer takes the result
- RSP_ID  out  1  index of the requester that owns the result
- RSP_LO, RSP_HI  out  DATA_W  captured OUT_LO/OUT_HI
- RSP_ZERO  out  1  captured ZERO, aligned to RSP_LO
- BUSY  out  1  high in every state except IDLE
- ALU_OP  out  OP_W; ALU_INPUTA, ALU_INPUTB  out  DATA_W; ALU_INCR_OP  out  1  (all registered)
- ALU_OUT_LO, ALU_OUT_HI  in  DATA_W; ALU_ZERO  in  1

Behaviour:
- **Reset (async, RST=1):**
  - State IDLE; all READY, RSP_VALID and BUSY = 0.
  - RSP_* = 0.
  - ALU_OP = 3'b111 (ALU default, zero output); ALU operands = 0; ALU_INCR_OP = 0.
  - Round-robin pointer favours req0.
  - A reset mid-operation discards the in-flight op and any pending response; no READY is re-issued for it.
- **ALU timing contract:**
  - OUT_LO/OUT_HI are valid one clock after operands are presented.
  - ZERO reflects OUT_LO one clock after that.
  - Operands must be held for two consecutive cycles so OUT_LO is stable when ZERO is formed.
- **FSM states:** IDLE, ISSUE, WAIT, ZCAP, RESP.
  - IDLE: if any VALID, pulse the winner's READY for 1 cycle (combinational from state+VALID+pointer).
    - On that edge: latch op/operands/INCR into the ALU drive registers, latch RSP_ID, go to ISSUE.
  - ISSUE: ALU computes; operands held. Go to WAIT.
  - WAIT: operands held. At the edge, capture ALU_OUT_LO→RSP_LO and ALU_OUT_HI→RSP_HI; go to ZCAP.
  - ZCAP: at the edge, capture ALU_ZERO→RSP_ZERO; drive ALU idle (OP=111, INCR=0); set RSP_VALID; go to RESP.
  - RESP: RSP_VALID=1 and all RSP_* held stable until RSP_READY=1.
    - On the handshake edge, if any VALID is asserted in the same cycle, grant it immediately (READY pulse in RESP) and go to ISSUE. This is back-to-back operation.
    - Otherwise go to IDLE.
- **Latency:** accept edge → RSP_VALID high 3 cycles later. Throughput is one op per 4 cycles with RSP_READY held high.
- **Arbitration:**
  - Round-robin: pointer moves to the non-granted requester after each grant.
  - Single requester: it always wins regardless of pointer.
  - FIXED_PRIO=1 ignores the pointer.
- **Simultaneous events:** a requester whose VALID drops before a grant is simply not served. No READY is issued outside IDLE/RESP-handshake cycles.
- **Width rules:**
  - MUL result split LO = bits[9:0], HI = bits[19:10].
  - For all non-MUL ops HI = 0.
  - INCR wraps 1023→0.
  - No arithmetic in this block; values pass through unchanged.
- **Undefined ALU outputs after power-up:** they are never sampled, because capture occurs only in WAIT/ZCAP.

Decomposition:
- Package alu_ctrl_pkg: opcode localparams (OP_ADD..OP_PASS, OP_NOP=3'b111) and the FSM state encoding.
- One sub-module, rr_arb2: 2-way round-robin arbiter with FIXED_PRIO option, grant-advance input, pointer register on CLK/RST.

Test Plan:
- req0 ADD A=3 B=5 with RSP_READY=1 → REQ0_READY pulse; RSP_VALID 3 cycles later with LO=8, HI=0, ZERO=0, ID=0.
- req1 SUB A=7 B=7 → LO=0, ZERO=1. Then req1 XOR A=0x155 B=0x2AA → LO=0x3FF, ZERO=0, showing no stale ZERO.
- req0 MUL A=1023 B=1023 → LO=0x001, HI=0x3FE. Then req0 INCR A=1023 → LO=0, ZERO=1.
- Both VALID held with 4 queued ops each, RSP_READY=1 → grants alternate 0,1,0,1…, spaced 4 cycles apart. With FIXED_PRIO=1, all req0 ops complete first.
- RSP_READY=0 for 10 cycles in RESP → RSP_* stable, no READY to either requester. Release → immediate back-to-back grant.
- RST asserted during WAIT → all outputs at reset values within the same cycle (async), no RSP_VALID. After release, a new req0 PASS B=0x2A3 → LO=0x2A3.
